// File: rtl/ta_ldd_wdis_gen.sv
// ta_ldd_wdis_gen -- burst generator for per-channel laser-driver write-disable (1 = disabled).
// Rev 1.0
`default_nettype none

module ta_ldd_wdis_gen #(
  parameter int CH_NUM = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk200,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_NUM-1:0] cmd_mask,
  input  logic [CNT_W-1:0]  cmd_on_len,
  input  logic [CNT_W-1:0]  cmd_off_len,
  input  logic [7:0]        cmd_repeat,
  input  logic              abort,
  output logic [CH_NUM-1:0] com_wdis,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q;
  logic [CH_NUM-1:0]   mask_q;
  logic [CNT_W-1:0]    on_len_q;
  logic [CNT_W-1:0]    off_len_q;
  logic [CNT_W-1:0]    phase_cnt_q;
  logic [7:0]          pulse_cnt_q;
  logic [CH_NUM-1:0]   com_wdis_q;
  logic                done_q;
  logic                aborted_q;

  logic [CNT_W-1:0]    on_len_d;
  logic                accept_d;
  logic                phase_end_d;
  logic                last_pulse_d;

  // A zero enable length still produces a single ON cycle.
  assign on_len_d     = (cmd_on_len == '0) ? CNT_W'(1) : cmd_on_len;
  assign accept_d     = cmd_valid && !abort && (state_q == S_IDLE);
  assign phase_end_d  = (phase_cnt_q <= CNT_W'(1));
  assign last_pulse_d = (pulse_cnt_q <= 8'd1);

  always_ff @(posedge clk200) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      on_len_q    <= '0;
      off_len_q   <= '0;
      phase_cnt_q <= '0;
      pulse_cnt_q <= '0;
      com_wdis_q  <= '1;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (abort && (state_q != S_IDLE)) begin
        state_q    <= S_IDLE;
        com_wdis_q <= '1;
        aborted_q  <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            com_wdis_q <= '1;
            if (accept_d) begin
              mask_q      <= cmd_mask;
              on_len_q    <= on_len_d;
              off_len_q   <= cmd_off_len;
              pulse_cnt_q <= cmd_repeat;
              if (cmd_repeat == 8'd0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q     <= S_ON;
                phase_cnt_q <= on_len_d;
                com_wdis_q  <= ~cmd_mask;
              end
            end
          end
          S_ON: begin
            if (phase_end_d) begin
              if (!last_pulse_d) begin
                pulse_cnt_q <= pulse_cnt_q - 8'd1;
              end
              if (last_pulse_d) begin
                state_q    <= S_DONE;
                com_wdis_q <= '1;
                done_q     <= 1'b1;
              end else if (off_len_q != '0) begin
                state_q     <= S_OFF;
                phase_cnt_q <= off_len_q;
                com_wdis_q  <= '1;
              end else begin
                // Zero gap: restart ON directly so the output stays low.
                phase_cnt_q <= on_len_q;
                com_wdis_q  <= ~mask_q;
              end
            end else begin
              phase_cnt_q <= phase_cnt_q - CNT_W'(1);
            end
          end
          S_OFF: begin
            if (phase_end_d) begin
              state_q     <= S_ON;
              phase_cnt_q <= on_len_q;
              com_wdis_q  <= ~mask_q;
            end else begin
              phase_cnt_q <= phase_cnt_q - CNT_W'(1);
            end
          end
          default: begin
            state_q    <= S_IDLE;
            com_wdis_q <= '1;
          end
        endcase
      end
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign com_wdis  = com_wdis_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

`default_nettype wire

// File: tb/tb_ta_ldd_wdis_gen.sv
// ============================================================================
// Module      : tb_ta_ldd_wdis_gen
// Description : Scoreboard bench; expected per-cycle outputs queued at
//               stimulus time, plus reset-state and bounded-wait checks.
// Revision    : 1.1
// ============================================================================
`default_nettype none

module tb_ta_ldd_wdis_gen;

    logic        clk200 = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_mask;
    logic [15:0] cmd_on_len;
    logic [15:0] cmd_off_len;
    logic [7:0]  cmd_repeat;
    logic        abort;
    logic [2:0]  com_wdis;
    logic        busy;
    logic        done;
    logic        aborted;

    ta_ldd_wdis_gen #(.CH_NUM(3), .CNT_W(16)) dut (
        .clk200      (clk200),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mask    (cmd_mask),
        .cmd_on_len  (cmd_on_len),
        .cmd_off_len (cmd_off_len),
        .cmd_repeat  (cmd_repeat),
        .abort       (abort),
        .com_wdis    (com_wdis),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    always #5 clk200 = ~clk200;

    typedef struct packed {
        logic [2:0] wdis;
        logic       rdy;
        logic       bsy;
        logic       dn;
        logic       ab;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cycle     = 0;
    logic mon_en    = 1'b0;
    logic cur_ready = 1'b1;

    function automatic exp_t mk(input logic [2:0] w, input logic r, input logic b,
                                input logic d, input logic a);
        exp_t e;
        e.wdis = w; e.rdy = r; e.bsy = b; e.dn = d; e.ab = a;
        return e;
    endfunction

    task automatic push_burst(input logic [2:0] m, input int on, input int off, input int rep);
        int on_eff;
        on_eff = (on == 0) ? 1 : on;
        for (int p = 0; p < rep; p++) begin
            for (int k = 0; k < on_eff; k++) sb.push_back(mk(~m, 1'b0, 1'b1, 1'b0, 1'b0));
            if (p < rep - 1)
                for (int k = 0; k < off; k++) sb.push_back(mk(3'b111, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        sb.push_back(mk(3'b111, 1'b0, 1'b1, 1'b1, 1'b0));
    endtask

    task automatic drive(input logic r, input logic v, input logic [2:0] m, input int on,
                         input int off, input int rep, input logic ab);
        rst         = r;
        cmd_valid   = v;
        cmd_mask    = m;
        cmd_on_len  = 16'(on);
        cmd_off_len = 16'(off);
        cmd_repeat  = 8'(rep);
        abort       = ab;
        if (r) begin
            sb.delete();
        end else if (ab && !cur_ready) begin
            sb.delete();
            sb.push_back(mk(3'b111, 1'b1, 1'b0, 1'b0, 1'b1));
        end else if (v && !ab && cur_ready) begin
            push_burst(m, on, off, rep);
        end
        @(negedge clk200);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'($urandom), int'($urandom_range(0, 7)),
                                          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if ((com_wdis !== 3'b111) || (cmd_ready !== 1'b1) || (busy !== 1'b0) ||
            (done !== 1'b0) || (aborted !== 1'b0)) begin
            failures++;
            $display("FAIL reset_state %s got wdis=%b rdy=%b busy=%b done=%b aborted=%b",
                     tag, com_wdis, cmd_ready, busy, done, aborted);
        end
    endtask

    task automatic wait_done_or_fail(input int max_cycles, input int total_idle, input string tag);
        int n;
        n = 0;
        while ((done !== 1'b1) && (n < max_cycles)) begin
            idle(1);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL wait_expired %s no done within %0d cycles", tag, max_cycles);
        end
        if (total_idle > n) idle(total_idle - n);
    endtask

    always @(negedge clk200) begin
        if (mon_en) begin
            exp_t e, got;
            e = (sb.size() > 0) ? sb.pop_front() : mk(3'b111, 1'b1, 1'b0, 1'b0, 1'b0);
            got = mk(com_wdis, cmd_ready, busy, done, aborted);
            cur_ready = e.rdy;
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL outputs cycle=%0d got wdis=%b rdy=%b busy=%b done=%b aborted=%b expected wdis=%b rdy=%b busy=%b done=%b aborted=%b",
                         cycle, got.wdis, got.rdy, got.bsy, got.dn, got.ab, e.wdis, e.rdy, e.bsy, e.dn, e.ab);
            end
            cycle++;
        end
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_mask = '0; cmd_on_len = '0;
        cmd_off_len = '0; cmd_repeat = '0; abort = 1'b0;
        @(negedge clk200);
        #1;
        mon_en = 1'b1;
        drive(1'b1, 1'b1, 3'b111, 2, 2, 2, 1'b1);
        drive(1'b1, 1'b0, 3'b000, 0, 0, 0, 1'b0);
        check_reset_state("initial");
        idle(2);

        drive(1'b0, 1'b1, 3'b101, 4, 2, 3, 1'b0);  wait_done_or_fail(40, 20, "basic");
        drive(1'b0, 1'b1, 3'b111, 3, 0, 2, 1'b0);  wait_done_or_fail(20, 9, "back_to_back");
        drive(1'b0, 1'b1, 3'b011, 0, 5, 1, 1'b0);  idle(4);
        drive(1'b0, 1'b1, 3'b111, 3, 3, 0, 1'b0);  idle(3);
        drive(1'b0, 1'b1, 3'b000, 2, 1, 2, 1'b0);  idle(8);

        drive(1'b0, 1'b1, 3'b101, 2, 3, 2, 1'b0);  idle(2);
        drive(1'b0, 1'b0, 3'b000, 0, 0, 0, 1'b1);  idle(2);
        drive(1'b0, 1'b1, 3'b110, 2, 1, 1, 1'b0);  idle(1);
        drive(1'b0, 1'b1, 3'b111, 4, 4, 4, 1'b1);  idle(2);
        drive(1'b0, 1'b1, 3'b010, 1, 1, 1, 1'b1);  idle(3);

        drive(1'b0, 1'b1, 3'b111, 5, 1, 2, 1'b0);  idle(2);
        drive(1'b1, 1'b1, 3'b111, 1, 1, 1, 1'b0);
        check_reset_state("mid_on");
        drive(1'b0, 1'b1, 3'b001, 2, 1, 2, 1'b0);  idle(8);

        for (int i = 0; i < 30; i++)
            drive(1'b0, 1'b1, 3'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), 1'b0);
        idle(15);

        for (int i = 0; i < 4000; i++) begin
            logic r, v, a;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 1) == 1);
            a = ($urandom_range(0, 29) == 0);
            drive(r, v, 3'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 4)), a);
        end
        idle(30);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
